// File: rtl/decode_stage_pipe.sv
// decode_stage_pipe: registered RV32/RV64 decode stage with a one-entry skid buffer toward the EU.
// Regfile read ports are driven combinationally from inst_i; the decoded bundle is registered.
module decode_stage_pipe #(
    parameter int XLEN  = 64,
    parameter int PID_W = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 flush_i,
    input  logic                                 valid_i,
    output logic                                 ready_o,
    input  logic [31:0]                          inst_i,
    input  logic [PID_W-1:0]                     pid_i,
    output logic [4:0]                           rs1_addr_o,
    output logic [4:0]                           rs2_addr_o,
    output logic                                 rs1_ren_o,
    output logic                                 rs2_ren_o,
    input  logic [XLEN-1:0]                      rs1_data_i,
    input  logic [XLEN-1:0]                      rs2_data_i,
    output logic                                 valid_o,
    input  logic                                 ready_i,
    output logic [6:0]                           opcode_o,
    output logic [2:0]                           funct3_o,
    output logic [6:0]                           funct7_o,
    output logic [4:0]                           rd_addr_o,
    output logic                                 rd_we_o,
    output logic                                 rd_late_o,
    output logic [XLEN-1:0]                      rs1_data_o,
    output logic [XLEN-1:0]                      rs2_data_o,
    output logic [XLEN-1:0]                      imm_o,
    output logic [((XLEN == 64) ? 6 : 5)-1:0]    shamt_o,
    output logic                                 illegal_o,
    output logic [PID_W-1:0]                     pid_o
);
    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5;

    typedef struct packed {
        logic [6:0]         opcode;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [4:0]         rd_addr;
        logic               rd_we;
        logic               rd_late;
        logic [XLEN-1:0]    rs1_data;
        logic [XLEN-1:0]    rs2_data;
        logic [XLEN-1:0]    imm;
        logic [SHAMT_W-1:0] shamt;
        logic               illegal;
        logic [PID_W-1:0]   pid;
    } bundle_t;

    logic [6:0]  opc;
    logic [2:0]  f3;
    logic        is_lui, is_auipc, is_jal, is_jalr, is_branch, is_load, is_store;
    logic        is_opimm, is_op, is_system, is_amo, is_fp, is_opimm32, is_op32;
    logic        supported, sh_f3, bad_shift, illegal, rd_cls;
    logic [31:0] imm32;
    bundle_t     dec, out_q, skid_q;
    logic        out_v, skid_v, accept;

    assign opc        = inst_i[6:0];
    assign f3         = inst_i[14:12];
    assign is_lui     = opc == 7'b0110111;
    assign is_auipc   = opc == 7'b0010111;
    assign is_jal     = opc == 7'b1101111;
    assign is_jalr    = opc == 7'b1100111;
    assign is_branch  = opc == 7'b1100011;
    assign is_load    = opc == 7'b0000011;
    assign is_store   = opc == 7'b0100011;
    assign is_opimm   = opc == 7'b0010011;
    assign is_op      = opc == 7'b0110011;
    assign is_system  = opc == 7'b1110011;
    assign is_amo     = opc == 7'b0101111;
    assign is_fp      = opc == 7'b1010011;
    // The 32-bit-word opcodes simply do not exist on an RV32 build.
    assign is_opimm32 = (XLEN == 64) && opc == 7'b0011011;
    assign is_op32    = (XLEN == 64) && opc == 7'b0111011;

    assign supported = is_lui | is_auipc | is_jal | is_jalr | is_branch | is_load | is_store |
                       is_opimm | is_op | is_system | is_amo | is_fp | is_opimm32 | is_op32;
    assign sh_f3     = f3 == 3'b001 || f3 == 3'b101;
    assign bad_shift = is_opimm && sh_f3 && ((XLEN == 32 && inst_i[25]) ||
                       !(inst_i[31:26] == 6'b000000 || (inst_i[31:26] == 6'b010000 && f3 == 3'b101)));
    assign illegal   = inst_i[1:0] != 2'b11 || !supported || bad_shift;
    assign rd_cls    = is_lui | is_auipc | is_jal | is_jalr | is_load | is_opimm | is_op |
                       is_opimm32 | is_op32 | is_amo | is_fp | (is_system && f3 != 3'b000);

    assign rs1_ren_o  = !illegal && !(is_lui || is_auipc || is_jal) &&
                        !(is_system && (f3 == 3'b000 || f3 == 3'b100));
    assign rs2_ren_o  = !illegal && (is_branch || is_store || is_op || is_op32 || is_amo || is_fp);
    assign rs1_addr_o = rs1_ren_o ? inst_i[19:15] : 5'd0;
    assign rs2_addr_o = rs2_ren_o ? inst_i[24:20] : 5'd0;

    assign imm32 = (is_lui || is_auipc) ? {inst_i[31:12], 12'b0}
                 : is_jal    ? {{12{inst_i[31]}}, inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0}
                 : is_branch ? {{20{inst_i[31]}}, inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0}
                 : is_store  ? {{21{inst_i[31]}}, inst_i[30:25], inst_i[11:7]}
                 : (is_jalr || is_load || is_opimm || is_opimm32 || is_system)
                             ? {{21{inst_i[31]}}, inst_i[30:20]} : 32'd0;

    always_comb begin
        dec          = '0;
        dec.opcode   = opc;
        dec.funct3   = f3;
        dec.funct7   = inst_i[31:25];
        dec.rd_addr  = rd_cls ? inst_i[11:7] : 5'd0;
        dec.rd_we    = rd_cls && !illegal && inst_i[11:7] != 5'd0;
        dec.rd_late  = is_load || ((is_op || is_op32) && inst_i[31:25] == 7'b0000001);
        dec.rs1_data = rs1_ren_o ? rs1_data_i : '0;
        dec.rs2_data = rs2_ren_o ? rs2_data_i : '0;
        dec.imm      = XLEN'($signed(imm32));
        dec.shamt    = (is_opimm && sh_f3) ? inst_i[20+SHAMT_W-1:20]
                     : (is_opimm32 && sh_f3) ? SHAMT_W'(inst_i[24:20]) : '0;
        dec.illegal  = illegal;
        dec.pid      = pid_i;
    end

    assign accept = valid_i && ready_o;

    // The output slot drains from the skid first, so order is preserved across stalls.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_q  <= '0;
            skid_q <= '0;
        end else if (flush_i) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
        end else if (!out_v || ready_i) begin
            out_v  <= skid_v || accept;
            skid_v <= 1'b0;
            if (skid_v)
                out_q <= skid_q;
            else if (accept)
                out_q <= dec;
        end else if (accept) begin
            skid_v <= 1'b1;
            skid_q <= dec;
        end
    end

    assign ready_o    = !skid_v;
    assign valid_o    = out_v;
    assign opcode_o   = out_q.opcode;
    assign funct3_o   = out_q.funct3;
    assign funct7_o   = out_q.funct7;
    assign rd_addr_o  = out_q.rd_addr;
    assign rd_we_o    = out_q.rd_we;
    assign rd_late_o  = out_q.rd_late;
    assign rs1_data_o = out_q.rs1_data;
    assign rs2_data_o = out_q.rs2_data;
    assign imm_o      = out_q.imm;
    assign shamt_o    = out_q.shamt;
    assign illegal_o  = out_q.illegal;
    assign pid_o      = out_q.pid;
endmodule

// File: tb/tb_decode_stage_pipe.sv
// tb_decode_stage_pipe: directed plus random stimulus on an RV64 and an RV32 instance fed in parallel,
// checked against a queue-of-bundles reference model decoded from the ISA rules.
module tb_decode_stage_pipe;
    logic        clk = 1'b0;
    logic        rst, flush_i, valid_i, ready_i;
    logic [31:0] inst_i;
    logic [1:0]  pid_i;
    logic [63:0] d1, d2;

    logic        r64_ready, r64_ren1, r64_ren2, r64_valid, r64_we, r64_late, r64_ill;
    logic [4:0]  r64_a1, r64_a2, r64_rd;
    logic [6:0]  r64_opc, r64_f7;
    logic [2:0]  r64_f3;
    logic [63:0] r64_d1, r64_d2, r64_imm;
    logic [5:0]  r64_sh;
    logic [1:0]  r64_pid;

    logic        r32_ready, r32_ren1, r32_ren2, r32_valid, r32_we, r32_late, r32_ill;
    logic [4:0]  r32_a1, r32_a2, r32_rd;
    logic [6:0]  r32_opc, r32_f7;
    logic [2:0]  r32_f3;
    logic [31:0] r32_d1, r32_d2, r32_imm;
    logic [4:0]  r32_sh;
    logic [1:0]  r32_pid;

    decode_stage_pipe #(.XLEN(64), .PID_W(2)) u64 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r64_ready),
        .inst_i(inst_i), .pid_i(pid_i), .rs1_addr_o(r64_a1), .rs2_addr_o(r64_a2),
        .rs1_ren_o(r64_ren1), .rs2_ren_o(r64_ren2), .rs1_data_i(d1), .rs2_data_i(d2),
        .valid_o(r64_valid), .ready_i(ready_i), .opcode_o(r64_opc), .funct3_o(r64_f3),
        .funct7_o(r64_f7), .rd_addr_o(r64_rd), .rd_we_o(r64_we), .rd_late_o(r64_late),
        .rs1_data_o(r64_d1), .rs2_data_o(r64_d2), .imm_o(r64_imm), .shamt_o(r64_sh),
        .illegal_o(r64_ill), .pid_o(r64_pid));

    decode_stage_pipe #(.XLEN(32), .PID_W(2)) u32 (
        .clk(clk), .rst(rst), .flush_i(flush_i), .valid_i(valid_i), .ready_o(r32_ready),
        .inst_i(inst_i), .pid_i(pid_i), .rs1_addr_o(r32_a1), .rs2_addr_o(r32_a2),
        .rs1_ren_o(r32_ren1), .rs2_ren_o(r32_ren2), .rs1_data_i(d1[31:0]), .rs2_data_i(d2[31:0]),
        .valid_o(r32_valid), .ready_i(ready_i), .opcode_o(r32_opc), .funct3_o(r32_f3),
        .funct7_o(r32_f7), .rd_addr_o(r32_rd), .rd_we_o(r32_we), .rd_late_o(r32_late),
        .rs1_data_o(r32_d1), .rs2_data_o(r32_d2), .imm_o(r32_imm), .shamt_o(r32_sh),
        .illegal_o(r32_ill), .pid_o(r32_pid));

    always #5 clk = ~clk;

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd, a1, a2;
        logic        we, late, ill, e1, e2;
        logic [63:0] d1, d2, imm;
        logic [5:0]  sh;
        logic [1:0]  pid;
    } exp_t;

    int          checks = 0;
    int          errors = 0;
    exp_t        q64[$], q32[$];
    logic [4:0]  seen[$];
    logic [6:0]  ops[16] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13,
                             7'h33, 7'h73, 7'h2F, 7'h53, 7'h1B, 7'h3B, 7'h0F, 7'h07};

    function automatic exp_t ref_dec(input logic [31:0] in, input logic [1:0] pid,
                                     input logic [63:0] a, input logic [63:0] b, input int xl);
        exp_t e;
        bit wr = 0, r1 = 0, r2 = 0, ok = 1, sft;
        logic [63:0] imm_i, imm_s, imm_b, imm_j, imm_u;
        imm_i = {{52{in[31]}}, in[31:20]};
        imm_s = {{52{in[31]}}, in[31:25], in[11:7]};
        imm_b = {{52{in[31]}}, in[7], in[30:25], in[11:8], 1'b0};
        imm_j = {{44{in[31]}}, in[19:12], in[20], in[30:21], 1'b0};
        imm_u = {{32{in[31]}}, in[31:12], 12'b0};
        e = '{default: '0};
        e.opc = in[6:0];
        e.f3 = in[14:12];
        e.f7 = in[31:25];
        e.pid = pid;
        sft = e.f3 == 3'd1 || e.f3 == 3'd5;
        case (e.opc)
            7'h37, 7'h17: begin wr = 1; e.imm = imm_u; end
            7'h6F: begin wr = 1; e.imm = imm_j; end
            7'h67: begin wr = 1; r1 = 1; e.imm = imm_i; end
            7'h63: begin r1 = 1; r2 = 1; e.imm = imm_b; end
            7'h03: begin wr = 1; r1 = 1; e.imm = imm_i; e.late = 1; end
            7'h23: begin r1 = 1; r2 = 1; e.imm = imm_s; end
            7'h13: begin
                wr = 1; r1 = 1; e.imm = imm_i;
                if (sft) begin
                    e.sh = (xl == 64) ? in[25:20] : {1'b0, in[24:20]};
                    if ((xl == 32 && in[25]) || !(in[31:26] == 6'h00 || (in[31:26] == 6'h10 && e.f3 == 3'd5)))
                        ok = 0;
                end
            end
            7'h33: begin wr = 1; r1 = 1; r2 = 1; e.late = e.f7 == 7'd1; end
            7'h73: begin r1 = e.f3 != 3'd0 && e.f3 != 3'd4; wr = e.f3 != 3'd0; e.imm = imm_i; end
            7'h2F, 7'h53: begin wr = 1; r1 = 1; r2 = 1; end
            7'h1B: if (xl == 64) begin
                wr = 1; r1 = 1; e.imm = imm_i;
                if (sft) e.sh = {1'b0, in[24:20]};
            end else ok = 0;
            7'h3B: if (xl == 64) begin wr = 1; r1 = 1; r2 = 1; e.late = e.f7 == 7'd1; end else ok = 0;
            default: ok = 0;
        endcase
        e.ill = !ok;
        e.rd  = wr ? in[11:7] : 5'd0;
        e.we  = wr && ok && in[11:7] != 5'd0;
        e.e1  = r1 && ok;
        e.e2  = r2 && ok;
        e.a1  = e.e1 ? in[19:15] : 5'd0;
        e.a2  = e.e2 ? in[24:20] : 5'd0;
        e.d1  = e.e1 ? a : 64'd0;
        e.d2  = e.e2 ? b : 64'd0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string p, input exp_t e, input logic [63:0] m,
                           input logic [6:0] opc, input logic [2:0] f3, input logic [6:0] f7,
                           input logic [4:0] rd, input logic we, input logic late,
                           input logic [63:0] o1, input logic [63:0] o2, input logic [63:0] imm,
                           input logic [5:0] sh, input logic ill, input logic [1:0] pid);
        chk({p, "_opcode"}, 64'(opc), 64'(e.opc));
        chk({p, "_funct3"}, 64'(f3), 64'(e.f3));
        chk({p, "_funct7"}, 64'(f7), 64'(e.f7));
        chk({p, "_rd_addr"}, 64'(rd), 64'(e.rd));
        chk({p, "_rd_we"}, 64'(we), 64'(e.we));
        chk({p, "_rd_late"}, 64'(late), 64'(e.late));
        chk({p, "_rs1_data"}, o1, e.d1 & m);
        chk({p, "_rs2_data"}, o2, e.d2 & m);
        chk({p, "_imm"}, imm, e.imm & m);
        chk({p, "_shamt"}, 64'(sh), 64'(e.sh));
        chk({p, "_illegal"}, 64'(ill), 64'(e.ill));
        chk({p, "_pid"}, 64'(pid), 64'(e.pid));
    endtask

    task automatic sample();
        exp_t c64, c32;
        @(negedge clk);
        c64 = ref_dec(inst_i, pid_i, d1, d2, 64);
        c32 = ref_dec(inst_i, pid_i, d1, d2, 32);
        chk("rd_port64", {56'd0, r64_ren1, r64_ren2, r64_a1[4:0], 1'b0},
            {56'd0, c64.e1, c64.e2, c64.a1, 1'b0});
        chk("rs2_addr64", 64'(r64_a2), 64'(c64.a2));
        chk("rd_port32", {56'd0, r32_ren1, r32_ren2, r32_a1[4:0], 1'b0},
            {56'd0, c32.e1, c32.e2, c32.a1, 1'b0});
        chk("rs2_addr32", 64'(r32_a2), 64'(c32.a2));
        chk("valid64", 64'(r64_valid), 64'(q64.size() > 0));
        chk("ready64", 64'(r64_ready), 64'(q64.size() < 2));
        chk("valid32", 64'(r32_valid), 64'(q32.size() > 0));
        chk("ready32", 64'(r32_ready), 64'(q32.size() < 2));
        if (q64.size() > 0)
            chk_out("u64", q64[0], '1, r64_opc, r64_f3, r64_f7, r64_rd, r64_we, r64_late,
                    r64_d1, r64_d2, r64_imm, r64_sh, r64_ill, r64_pid);
        if (q32.size() > 0)
            chk_out("u32", q32[0], 64'hFFFF_FFFF, r32_opc, r32_f3, r32_f7, r32_rd, r32_we, r32_late,
                    {32'd0, r32_d1}, {32'd0, r32_d2}, {32'd0, r32_imm}, {1'b0, r32_sh}, r32_ill, r32_pid);
        if (r64_valid === 1'b1 && ready_i)
            seen.push_back(r64_rd);
    endtask

    // Model: the stage is a FIFO of at most two decoded bundles.
    task automatic tick();
        bit acc;
        sample();
        @(posedge clk);
        acc = valid_i && q64.size() < 2;
        if (rst || flush_i) begin
            q64.delete();
            q32.delete();
        end else begin
            if (q64.size() > 0 && ready_i) begin
                void'(q64.pop_front());
                void'(q32.pop_front());
            end
            if (acc) begin
                q64.push_back(ref_dec(inst_i, pid_i, d1, d2, 64));
                q32.push_back(ref_dec(inst_i, pid_i, d1, d2, 32));
            end
        end
        #1;
    endtask

    task automatic drive(input logic [31:0] in, input logic v, input logic r);
        inst_i  = in;
        valid_i = v;
        ready_i = r;
    endtask

    initial begin
        rst = 1; flush_i = 0; valid_i = 0; ready_i = 1; inst_i = 0; pid_i = 0; d1 = 0; d2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid", 64'(r64_valid), 64'd0);
        chk("rst_ready", 64'(r64_ready), 64'd1);
        chk("rst_imm", r64_imm, 64'd0);
        chk("rst_rd", 64'(r64_rd), 64'd0);
        chk("rst_rs1d", r64_d1, 64'd0);
        chk("rst_valid32", 64'(r32_valid), 64'd0);
        rst = 0;

        d1 = 64'd7; d2 = 64'h1234; pid_i = 2'd1;
        drive(32'hFFF08293, 1, 1);
        #1 chk("addi_rs1_addr", 64'(r64_a1), 64'd1);
        tick();
        chk("addi_valid", 64'(r64_valid), 64'd1);
        chk("addi_rd", 64'(r64_rd), 64'd5);
        chk("addi_we", 64'(r64_we), 64'd1);
        chk("addi_imm", r64_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_rs1d", r64_d1, 64'd7);
        chk("addi_ill", 64'(r64_ill), 64'd0);

        drive(32'h800000B7, 1, 1);
        #1 chk("lui_ren", 64'(r64_ren1), 64'd0);
        tick();
        chk("lui_imm", r64_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_we", 64'(r64_we), 64'd1);

        drive(32'h022081B3, 1, 1);
        #1 chk("mul_addrs", {54'd0, r64_a1, r64_a2}, {54'd0, 5'd1, 5'd2});
        tick();
        chk("mul_we_late", {62'd0, r64_we, r64_late}, 64'd3);
        drive(32'h02208033, 1, 1);
        tick();
        chk("mul_x0_we", 64'(r64_we), 64'd0);
        drive(32'h0, 0, 1);
        tick();

        // Three back-to-back instructions against a stalled EU.
        seen.delete();
        drive(32'h00100093, 1, 0); tick();
        drive(32'h00100113, 1, 0); tick();
        chk("bp_ready_low", 64'(r64_ready), 64'd0);
        drive(32'h00100193, 1, 0); tick();
        tick();
        ready_i = 1; tick(); tick();
        valid_i = 0; tick(); tick();
        chk("bp_count", 64'(seen.size()), 64'd3);
        for (int i = 0; i < 3 && i < seen.size(); i++)
            chk("bp_order", 64'(seen[i]), 64'(i + 1));

        drive(32'h00100213, 1, 0); tick();
        drive(32'h00100293, 1, 0); tick();
        flush_i = 1; drive(32'h00100313, 1, 0); tick();
        flush_i = 0; valid_i = 0;
        chk("flush_valid", 64'(r64_valid), 64'd0);
        chk("flush_ready", 64'(r64_ready), 64'd1);
        ready_i = 1; seen.delete();
        repeat (3) tick();
        chk("flush_none", 64'(seen.size()), 64'd0);

        drive(32'h0010809B, 1, 1); tick();
        chk("addiw32_ill", 64'(r32_ill), 64'd1);
        chk("addiw32_we", 64'(r32_we), 64'd0);
        chk("addiw64_ill", 64'(r64_ill), 64'd0);
        drive(32'h02009093, 1, 1); tick();
        chk("slli32_ill", 64'(r32_ill), 64'd1);
        chk("slli64_ill", 64'(r64_ill), 64'd0);
        chk("slli64_sh", 64'(r64_sh), 64'd32);
        drive(32'h40009093, 1, 1); tick();
        chk("slli_f6_ill", 64'(r64_ill), 64'd1);
        drive(32'h4020D093, 1, 1); tick();
        chk("srai_ill", 64'(r64_ill), 64'd0);

        drive(32'h00100093, 1, 0); tick(); tick();
        chk("full_ready", 64'(r64_ready), 64'd0);
        rst = 1; tick();
        rst = 0; valid_i = 0;
        chk("rstfull_valid", 64'(r64_valid), 64'd0);
        chk("rstfull_ready", 64'(r64_ready), 64'd1);
        chk("rstfull_valid32", 64'(r32_valid), 64'd0);

        for (int n = 0; n < 400; n++) begin
            logic [31:0] w;
            w = $urandom;
            w[6:0] = ops[$urandom_range(0, 15)];
            if ($urandom_range(0, 9) == 0) w[1:0] = 2'($urandom);
            if (w[6:0] == 7'h13) begin
                if ($urandom_range(0, 2) == 0) w[31:26] = 6'h00;
                else if ($urandom_range(0, 1) == 0) w[31:26] = 6'h10;
            end
            if ((w[6:0] == 7'h33 || w[6:0] == 7'h3B) && $urandom_range(0, 1) == 1) w[31:25] = 7'd1;
            d1 = {$urandom, $urandom};
            d2 = {$urandom, $urandom};
            pid_i = 2'($urandom);
            flush_i = $urandom_range(0, 24) == 0;
            drive(w, $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            tick();
        end
        flush_i = 0;
        drive(32'h0, 0, 1);
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/decode_stage_pipe.md
Name: decode_stage_pipe

Overview:
- Registered, parametrised successor to the way-level instruction decoder.
- Decodes one RV32/RV64 instruction per cycle from IFU, drives regfile read addresses combinationally, and captures the decoded bundle plus operands into an output register.
- Output register is backed by a one-entry skid buffer, so the valid/ready handshake toward the EU is fully registered.
- Adds illegal-instruction detection, flush, and split early/late rd-writeback flags.

Parameters:
XLEN, 64, datapath width; legal values 32 or 64.
PID_W, 2, width of the way pID tag.
SHAMT_W, (XLEN==64 ? 6 : 5), shift-amount width; derived, not overridable.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush_i  in  1  discard all held and incoming instructions
valid_i  in  1  IFU instruction valid
ready_o  out  1  stage can accept (to IFU)
inst_i  in  32  instruction word
pid_i  in  PID_W  way pID tag
rs1_addr_o / rs2_addr_o  out  5 each  combinational regfile read addresses
rs1_ren_o / rs2_ren_o  out  1 each  combinational regfile read enables
rs1_data_i / rs2_data_i  in  XLEN each  regfile read data, same cycle as inst_i
valid_o  out  1  decoded bundle valid (to EU)
ready_i  in  1  EU accepts
opcode_o / funct3_o / funct7_o  out  7 / 3 / 7  registered fields
rd_addr_o  out  5  destination register
rd_we_o  out  1  instruction writes rd (rd != x0)
rd_late_o  out  1  rd data produced after EX (load, M-extension)
rs1_data_o / rs2_data_o  out  XLEN each  registered operands (0 when matching ren is 0)
imm_o  out  XLEN  sign-extended immediate
shamt_o  out  SHAMT_W  shift amount; 0 unless a shift-immediate
illegal_o  out  1  illegal/unsupported encoding
pid_o  out  PID_W  registered pID

Behaviour:
- Reset, synchronous: valid_o=0, skid empty, ready_o=1, all data outputs 0.
- Accept when valid_i && ready_o. Accepted instruction appears on outputs with valid_o=1 the next cycle (latency 1).
- ready_o = !skid_valid, driven from a register (no combinational path from ready_i).
- Occupancy states:
  - EMPTY: accept → ONE.
  - ONE: accept && ready_i → ONE; accept && !ready_i → FULL, incoming bundle goes to skid; !accept && ready_i → EMPTY.
  - FULL: ready_i → ONE, skid moves to output; ready_i low → hold.
- Output bundle is stable while valid_o && !ready_i. Order is strictly preserved.
- flush_i has priority over everything:
  - next cycle is EMPTY, valid_o=0, ready_o=1;
  - an instruction accepted in the flush cycle is discarded.
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, SYSTEM, AMO(0101111), FP-OP(1010011). OP-IMM-32 and OP-32 are supported only when XLEN=64.
- Read enables and addresses:
  - rs1 is read for all except LUI/AUIPC/JAL. For SYSTEM, rs1 is read only when funct3 is in {001,010,011,101,110,111}.
  - rs2 is read for BRANCH, STORE, OP, OP-32, AMO, FP-OP.
  - A disabled address is driven as 0.
- Destination:
  - rd_addr = inst[11:7] for every rd-writing class, JALR included; otherwise 0.
  - rd_we=1 for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, OP-IMM-32, OP-32, AMO, FP-OP, and for SYSTEM with funct3 != 000. Forced to 0 when rd=x0.
  - rd_late=1 for LOAD, and for OP/OP-32 with funct7=0000001. Only meaningful when rd_we=1.
- Immediate, sign-extended to XLEN:
  - I-type: JALR, LOAD, OP-IMM, OP-IMM-32, SYSTEM.
  - S: STORE. B: BRANCH, bit0=0. J: JAL, bit0=0.
  - U: LUI/AUIPC, inst[31:12]<<12, then sign-extended from bit 31.
  - OP, OP-32, AMO, FP-OP: 0.
- shamt:
  - OP-IMM, funct3 001/101: shamt = inst[20+SHAMT_W-1:20].
  - OP-IMM-32, funct3 001/101: shamt = {0, inst[24:20]}.
- illegal_o=1 when any of:
  - inst[1:0] != 11;
  - unsupported opcode;
  - XLEN=32 and inst[25]=1 on an OP-IMM shift;
  - OP-IMM shift with inst[31:26] not 000000 or 010000 (010000 valid only with funct3 101).
- An illegal bundle still flows with valid_o=1: rd_we=0, ren=0, other fields decoded raw.

Test Plan:
- XLEN=64, inst 0xFFF08293 (addi x5,x1,-1), rs1_data=7 → next cycle valid_o=1, rd_addr=5, rd_we=1, imm=0xFFFFFFFFFFFFFFFF, rs1_addr=1, rs1_data_o=7, illegal_o=0.
- XLEN=64, inst 0x800000B7 (lui x1,0x80000) → imm=0xFFFFFFFF80000000, rs1_ren=0, rd_we=1.
- inst 0x022081B3 (mul x3,x1,x2) → rs1_addr=1, rs2_addr=2, rd_we=1, rd_late=1; same with rd=x0 → rd_we=0.
- Three back-to-back valid instructions, ready_i held 0 for 3 cycles → ready_o drops after the 2nd accept, 3rd held at IFU; on release, outputs appear in order 1, 2, 3 with no loss or duplicates.
- FULL state, flush_i=1 with valid_i=1 → next cycle valid_o=0, ready_o=1; the flushed-cycle instruction never appears.
- XLEN=32, inst 0x0010809B (addiw) → illegal_o=1, rd_we=0; slli with inst[25]=1 → illegal_o=1; rst mid-FULL → valid_o=0, ready_o=1 the next cycle.
